// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF-stage fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        DROP
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_INCR   = 4;

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry holding register for a response that arrives while the output slot is occupied.
module fetch_skid_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             drain,
    input  logic             clear,
    input  logic [WIDTH-1:0] din_data,
    input  logic [WIDTH-1:0] din_pc,
    output logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] pc,
    output logic             valid
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (clear || drain) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= din_data;
            pc    <= din_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: fetch PC, single-outstanding imem requests, IF/ID write side.
// Optional performance counters when FETCH_PERF_EN is defined.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned             DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]   RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stallF,
    input  logic                  PCSrcE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instrF,
    output logic [DATA_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0] PCPlus4F,
`ifdef FETCH_PERF_EN
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_redirects,
    output logic [31:0]           perf_stall_cycles,
`endif
    output logic                  fetch_validF
);

    localparam logic [DATA_WIDTH-1:0] NOP  = DATA_WIDTH'(NOP_INSTR);
    localparam logic [DATA_WIDTH-1:0] INCR = DATA_WIDTH'(PC_INCR);

    fetch_state_t          state;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] instr_q;
    logic [DATA_WIDTH-1:0] pcF_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic [DATA_WIDTH-1:0] skid_pc_q;
    logic                  skid_valid;
    logic                  free;
    logic                  consume;
    logic                  skid_load;
    logic                  skid_drain;

    assign free    = !valid_q || !stallF;
    assign consume = valid_q && !stallF;

    assign skid_load  = !PCSrcE && (state == WAIT) && imem_rvalid && !free;
    assign skid_drain = !PCSrcE && (state == HOLD) && free;

    fetch_skid_reg #(.WIDTH(DATA_WIDTH)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (skid_load),
        .drain    (skid_drain),
        .clear    (PCSrcE),
        .din_data (imem_rdata),
        .din_pc   (pc_q),
        .data     (skid_q),
        .pc       (skid_pc_q),
        .valid    (skid_valid)
    );

    assign imem_req     = rst_n && (state == REQ);
    assign imem_addr    = pc_q;
    assign instrF       = valid_q ? instr_q : NOP;
    assign PCF          = pcF_q;
    assign PCPlus4F     = pcF_q + INCR;
    assign fetch_validF = valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= REQ;
            pc_q    <= RESET_PC;
            pcF_q   <= RESET_PC;
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else begin
            if (consume)
                valid_q <= 1'b0;
            if (PCSrcE) begin
                // A response still owed for the old address must be swallowed in DROP.
                pc_q    <= PCTargetE;
                valid_q <= 1'b0;
                unique case (state)
                    REQ:     state <= imem_ready  ? DROP : REQ;
                    WAIT:    state <= imem_rvalid ? REQ  : DROP;
                    HOLD:    state <= REQ;
                    DROP:    state <= imem_rvalid ? REQ  : DROP;
                    default: state <= REQ;
                endcase
            end else begin
                unique case (state)
                    REQ: begin
                        if (imem_ready)
                            state <= WAIT;
                    end
                    WAIT: begin
                        if (imem_rvalid && free) begin
                            instr_q <= imem_rdata;
                            pcF_q   <= pc_q;
                            valid_q <= 1'b1;
                            pc_q    <= pc_q + INCR;
                            state   <= REQ;
                        end else if (imem_rvalid) begin
                            state <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (free && skid_valid) begin
                            instr_q <= skid_q;
                            pcF_q   <= skid_pc_q;
                            valid_q <= 1'b1;
                            pc_q    <= pc_q + INCR;
                            state   <= REQ;
                        end
                    end
                    DROP: begin
                        if (imem_rvalid)
                            state <= REQ;
                    end
                    default: state <= REQ;
                endcase
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched      <= '0;
            perf_redirects    <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (consume)
                perf_fetched <= perf_fetched + 32'd1;
            if (PCSrcE)
                perf_redirects <= perf_redirects + 32'd1;
            if (valid_q && stallF)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a hand-driven instruction memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        fetch_validF;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_redirects;
    logic [31:0] perf_stall_cycles;
`endif

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int acc_cnt = 0;
    int acc0;

    fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stallF       (stallF),
        .PCSrcE       (PCSrcE),
        .PCTargetE    (PCTargetE),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instrF       (instrF),
        .PCF          (PCF),
        .PCPlus4F     (PCPlus4F),
`ifdef FETCH_PERF_EN
        .perf_fetched      (perf_fetched),
        .perf_redirects    (perf_redirects),
        .perf_stall_cycles (perf_stall_cycles),
`endif
        .fetch_validF (fetch_validF)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (imem_req && imem_ready)
            acc_cnt <= acc_cnt + 1;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One k=1 transaction with no stall: request, response, then presentation.
    task automatic fetch(input logic [31:0] a);
        chk("f_req", {31'd0, imem_req}, 32'd1);
        chk("f_addr", imem_addr, a);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk("f_wait_req", {31'd0, imem_req}, 32'd0);
        chk("f_wait_valid", {31'd0, fetch_validF}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = mem(a);
        step();
        imem_rvalid = 1'b0;
        chk("f_valid", {31'd0, fetch_validF}, 32'd1);
        chk("f_pcf", PCF, a);
        chk("f_instr", instrF, mem(a));
        chk("f_pc4", PCPlus4F, a + 32'd4);
    endtask

    initial begin
        rst_n = 1'b0; stallF = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        step(); step();
        chk("rst_valid", {31'd0, fetch_validF}, 32'd0);
        chk("rst_pcf", PCF, 32'h0);
        chk("rst_pc4", PCPlus4F, 32'h4);
        chk("rst_instr", instrF, 32'h13);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("req_after_rst", {31'd0, imem_req}, 32'd1);

        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h8);

        // Stall while the next response arrives: it must be skid-held.
        stallF = 1'b1; imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk("st_pcf_a", PCF, 32'h8);
        chk("st_valid_a", {31'd0, fetch_validF}, 32'd1);
        imem_rvalid = 1'b1; imem_rdata = mem(32'hC);
        step();
        imem_rvalid = 1'b0;
        chk("st_hold_req", {31'd0, imem_req}, 32'd0);
        chk("st_pcf_b", PCF, 32'h8);
        step(); step();
        chk("st_pcf_c", PCF, 32'h8);
        chk("st_instr_c", instrF, mem(32'h8));
        chk("st_valid_c", {31'd0, fetch_validF}, 32'd1);
        stallF = 1'b0;
        step();
        chk("st_rel_pcf", PCF, 32'hC);
        chk("st_rel_instr", instrF, mem(32'hC));
        chk("st_rel_valid", {31'd0, fetch_validF}, 32'd1);
        chk("st_rel_req", {31'd0, imem_req}, 32'd1);
        chk("st_rel_addr", imem_addr, 32'h10);

        // Redirect while waiting for 0x10.
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        PCSrcE = 1'b1; PCTargetE = 32'h100;
        step();
        PCSrcE = 1'b0;
        chk("dr_req", {31'd0, imem_req}, 32'd0);
        chk("dr_valid", {31'd0, fetch_validF}, 32'd0);
        chk("dr_instr", instrF, 32'h13);
        chk("dr_pcf", PCF, 32'hC);
        chk("dr_addr", imem_addr, 32'h100);
        imem_rvalid = 1'b1; imem_rdata = mem(32'h10);
        step();
        imem_rvalid = 1'b0;
        chk("dr_drop_valid", {31'd0, fetch_validF}, 32'd0);
        chk("dr_drop_req", {31'd0, imem_req}, 32'd1);
        chk("dr_drop_addr", imem_addr, 32'h100);
        fetch(32'h100);

        // Redirect coinciding with a response while stalled.
        stallF = 1'b1; imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk("rs_valid_held", {31'd0, fetch_validF}, 32'd1);
        imem_rvalid = 1'b1; imem_rdata = mem(32'h104);
        PCSrcE = 1'b1; PCTargetE = 32'h200;
        step();
        PCSrcE = 1'b0; imem_rvalid = 1'b0; stallF = 1'b0;
        chk("rs_valid", {31'd0, fetch_validF}, 32'd0);
        chk("rs_instr", instrF, 32'h13);
        chk("rs_req", {31'd0, imem_req}, 32'd1);
        chk("rs_addr", imem_addr, 32'h200);

        // Memory not ready; redirect in the second cycle.
        acc0 = acc_cnt;
        chk("rl_addr1", imem_addr, 32'h200);
        step();
        PCSrcE = 1'b1; PCTargetE = 32'h300;
        step();
        PCSrcE = 1'b0;
        chk("rl_req3", {31'd0, imem_req}, 32'd1);
        chk("rl_addr3", imem_addr, 32'h300);
        step();
        chk("rl_addr4", imem_addr, 32'h300);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk("rl_wait_req", {31'd0, imem_req}, 32'd0);
        chk("rl_accepts", 32'(acc_cnt - acc0), 32'd1);
        imem_rvalid = 1'b1; imem_rdata = mem(32'h300);
        step();
        imem_rvalid = 1'b0;
        chk("rl_pcf", PCF, 32'h300);
        chk("rl_instr", instrF, mem(32'h300));

        // PC wraparound and unaligned redirect target.
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
        step();
        PCSrcE = 1'b0;
        chk("wr_valid", {31'd0, fetch_validF}, 32'd0);
        fetch(32'hFFFF_FFFC);
        chk("wr_addr", imem_addr, 32'h0);
        PCSrcE = 1'b1; PCTargetE = 32'h102;
        step();
        PCSrcE = 1'b0;
        fetch(32'h102);

        // Reset while a request is outstanding.
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        rst_n = 1'b0;
        step();
        chk("rr_valid", {31'd0, fetch_validF}, 32'd0);
        chk("rr_pcf", PCF, 32'h0);
        chk("rr_pc4", PCPlus4F, 32'h4);
        chk("rr_instr", instrF, 32'h13);
        chk("rr_req", {31'd0, imem_req}, 32'd0);
        chk("rr_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
        chk("rr_perf_fetched", perf_fetched, 32'h0);
        chk("rr_perf_redirects", perf_redirects, 32'h0);
        chk("rr_perf_stall", perf_stall_cycles, 32'h0);
`endif
        rst_n = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = mem(32'h106);
        step();
        imem_rvalid = 1'b0;
        chk("rr_stale_valid", {31'd0, fetch_validF}, 32'd0);
        chk("rr_stale_req", {31'd0, imem_req}, 32'd1);
        chk("rr_stale_addr", imem_addr, 32'h0);
        step();
        chk("rr_stale_valid2", {31'd0, fetch_validF}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
